// File: rtl/instr_mem_bank_if.sv
// Loader / fetch bus of the instruction memory bank.
// master: the loader and fetch unit driving the bank; slave: the bank itself.
interface instr_mem_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  i_load_start;
    logic                  i_load_valid;
    logic [DATA_WIDTH-1:0] i_load_data;
    logic                  i_load_last;
    logic                  o_load_ready;
    logic                  o_load_done;
    logic [ADDR_WIDTH:0]   o_load_count;
    logic                  i_fetch_en;
    logic [ADDR_WIDTH-1:0] i_fetch_addr;
    logic [DATA_WIDTH-1:0] o_instr;
    logic                  o_instr_valid;
    logic                  o_busy;

    modport master (
        output i_load_start, i_load_valid, i_load_data, i_load_last,
        output i_fetch_en, i_fetch_addr,
        input  o_load_ready, o_load_done, o_load_count,
        input  o_instr, o_instr_valid, o_busy
    );

    modport slave (
        input  i_load_start, i_load_valid, i_load_data, i_load_last,
        input  i_fetch_en, i_fetch_addr,
        output o_load_ready, o_load_done, o_load_count,
        output o_instr, o_instr_valid, o_busy
    );
endinterface

// File: rtl/instr_mem_bank.sv
// Instruction memory bank: sequential program load from address 0, then
// single-cycle-latency registered instruction fetch.
// Optional feature macro INSTR_MEM_PARITY_EN adds a per-word even-parity bit,
// a parity-inject input and a parity-error output.
module instr_mem_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    instr_mem_bank_if.slave bus
`ifdef INSTR_MEM_PARITY_EN
    ,
    input  logic i_par_inject,
    output logic o_par_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  instr_vld_q;
    logic                  cnt_clr;
    logic                  wr_en;
    logic                  fetch_acc;

    // Storage is deliberately not reset; a reset only abandons the load.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // The load count doubles as the write pointer.
    assign cnt_inc = cnt_q + 1'b1;

    // Next state and per-cycle controls; a load start in RUN beats a fetch.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        wr_en     = 1'b0;
        fetch_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_load_start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            end
            LOAD: begin
                if (bus.i_load_valid) begin
                    wr_en = 1'b1;
                    if (bus.i_load_last || (cnt_inc == DEPTH_CNT))
                        state_d = DONE;
                end
            end
            DONE: state_d = RUN;
            RUN: begin
                if (bus.i_load_start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end else if (bus.i_fetch_en) begin
                    fetch_acc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Load counter / write pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else if (wr_en)   cnt_q <= cnt_inc;
    end

    // Memory write port.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[cnt_q[ADDR_WIDTH-1:0]] <= bus.i_load_data;
    end

    // Registered fetch; o_instr holds its value between accepted fetches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_q     <= '0;
            instr_vld_q <= 1'b0;
        end else begin
            instr_vld_q <= fetch_acc;
            if (fetch_acc) instr_q <= mem[bus.i_fetch_addr];
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par_mem [RAM_DEPTH];
    logic par_err_q;

    // Parity write port; inject stores the inverted even-parity bit.
    always_ff @(posedge i_clk) begin
        if (wr_en) par_mem[cnt_q[ADDR_WIDTH-1:0]] <= (^bus.i_load_data) ^ i_par_inject;
    end

    // Parity check alongside the fetched word; low whenever no fetch was taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       par_err_q <= 1'b0;
        else if (fetch_acc) par_err_q <= (^mem[bus.i_fetch_addr]) ^ par_mem[bus.i_fetch_addr];
        else                par_err_q <= 1'b0;
    end

    assign o_par_err = par_err_q;
`endif

    assign bus.o_load_ready  = (state_q == LOAD);
    assign bus.o_load_done   = (state_q == DONE);
    assign bus.o_busy        = (state_q != RUN);
    assign bus.o_load_count  = cnt_q;
    assign bus.o_instr       = instr_q;
    assign bus.o_instr_valid = instr_vld_q;

endmodule

// File: tb/tb_instr_mem_bank.sv
// Randomized self-checking bench for instr_mem_bank against a word-array
// reference model of program loads and fetches.
module tb_instr_mem_bank;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef INSTR_MEM_PARITY_EN
    logic par_inject;
    logic par_err;
`endif

    instr_mem_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef INSTR_MEM_PARITY_EN
        ,
        .i_par_inject (par_inject),
        .o_par_err    (par_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: program words and inject flags by address, plus the
    // word the instruction register should currently hold.
    logic [DW-1:0] mdl   [DEPTH];
    bit            inj_m [DEPTH];
    logic [DW-1:0] exp_instr;

    logic [DW-1:0] wq[$];
    bit            iq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 64'(bus.o_load_ready), 64'(0));
        chk({tag, "_done"},  64'(bus.o_load_done),  64'(0));
        chk({tag, "_cnt"},   64'(bus.o_load_count), 64'(0));
        chk({tag, "_instr"}, 64'(bus.o_instr),      64'(0));
        chk({tag, "_vld"},   64'(bus.o_instr_valid),64'(0));
        chk({tag, "_busy"},  64'(bus.o_busy),       64'(1));
`ifdef INSTR_MEM_PARITY_EN
        chk({tag, "_par"},   64'(par_err),          64'(0));
`endif
    endtask

    // Full load of the words queued in wq/iq. Optionally collides the start
    // with a fetch, and re-asserts start alongside word restart_at.
    task automatic do_load(input bit use_last, input bit fetch_too, input int restart_at);
        int n;
        n = wq.size();
        bus.i_fetch_en   = fetch_too;
        bus.i_fetch_addr = AW'($urandom_range(0, DEPTH-1));
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        bus.i_fetch_en   = 1'b0;
        chk("ld_ready", 64'(bus.o_load_ready),  64'(1));
        chk("ld_cnt0",  64'(bus.o_load_count),  64'(0));
        chk("ld_vld",   64'(bus.o_instr_valid), 64'(0));
        chk("ld_busy",  64'(bus.o_busy),        64'(1));
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.i_load_valid = 1'b0;
                bus.i_load_last  = 1'($urandom_range(0, 1));
                bus.i_load_data  = $urandom;
                bus.i_fetch_en   = 1'($urandom_range(0, 1));
                bus.i_fetch_addr = AW'($urandom_range(0, DEPTH-1));
                step();
                bus.i_fetch_en = 1'b0;
                chk("gap_cnt",   64'(bus.o_load_count),  64'(i));
                chk("gap_ready", 64'(bus.o_load_ready),  64'(1));
                chk("gap_vld",   64'(bus.o_instr_valid), 64'(0));
            end
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = wq[i];
            bus.i_load_last  = use_last && (i == n-1);
            bus.i_load_start = (i == restart_at);
`ifdef INSTR_MEM_PARITY_EN
            par_inject = iq[i];
`endif
            step();
            bus.i_load_start = 1'b0;
            mdl[i]   = wq[i];
            inj_m[i] = iq[i];
            chk("wr_cnt", 64'(bus.o_load_count), 64'(i+1));
            if (i < n-1) chk("wr_ready", 64'(bus.o_load_ready), 64'(1));
        end
        chk("done_pulse", 64'(bus.o_load_done),  64'(1));
        chk("done_ready", 64'(bus.o_load_ready), 64'(0));
        chk("done_busy",  64'(bus.o_busy),       64'(1));
        // Extra word offered during DONE must not land anywhere.
        bus.i_load_valid = 1'b1;
        bus.i_load_data  = ~wq[0];
        bus.i_load_last  = 1'b1;
        step();
        bus.i_load_valid = 1'b0;
        bus.i_load_last  = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
        par_inject = 1'b0;
`endif
        chk("run_done",  64'(bus.o_load_done),  64'(0));
        chk("run_busy",  64'(bus.o_busy),       64'(0));
        chk("run_cnt",   64'(bus.o_load_count), 64'(n));
        chk("run_ready", 64'(bus.o_load_ready), 64'(0));
        chk("run_hold",  64'(bus.o_instr),      64'(exp_instr));
        wq.delete();
        iq.delete();
    endtask

    task automatic fetch_cyc(input bit en, input int a);
        bus.i_fetch_en   = en;
        bus.i_fetch_addr = AW'(a);
        step();
        bus.i_fetch_en = 1'b0;
        if (en) exp_instr = mdl[a];
        chk("f_vld",   64'(bus.o_instr_valid), 64'(en));
        chk("f_instr", 64'(bus.o_instr),       64'(exp_instr));
`ifdef INSTR_MEM_PARITY_EN
        chk("f_par",   64'(par_err),           64'(en ? inj_m[a] : 1'b0));
`endif
    endtask

    task automatic queue_random(input int n, input bit with_inj);
        for (int i = 0; i < n; i++) begin
            wq.push_back($urandom);
`ifdef INSTR_MEM_PARITY_EN
            iq.push_back(with_inj ? 1'($urandom_range(0, 1)) : 1'b0);
`else
            iq.push_back(with_inj & 1'b0);
`endif
        end
    endtask

    initial begin
        bus.i_load_start = 1'b0;
        bus.i_load_valid = 1'b0;
        bus.i_load_data  = '0;
        bus.i_load_last  = 1'b0;
        bus.i_fetch_en   = 1'b0;
        bus.i_fetch_addr = '0;
`ifdef INSTR_MEM_PARITY_EN
        par_inject = 1'b0;
`endif
        exp_instr = '0;

        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetch in IDLE is dropped.
        bus.i_fetch_en = 1'b1;
        step();
        bus.i_fetch_en = 1'b0;
        chk("idle_vld",  64'(bus.o_instr_valid), 64'(0));
        chk("idle_busy", 64'(bus.o_busy),        64'(1));

        // Directed four-word program.
        wq = '{32'h11, 32'h22, 32'h33, 32'h44};
        iq = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_load(1'b1, 1'b0, -1);
        fetch_cyc(1'b1, 2);
        fetch_cyc(1'b1, 0);
        fetch_cyc(1'b1, 3);
        fetch_cyc(1'b0, 0);
        fetch_cyc(1'b0, 0);
        chk("held_44", 64'(bus.o_instr), 64'(32'h44));

        // Depth-filling load with no last flag and a restart attempt mid-load.
        queue_random(DEPTH, 1'b1);
        wq[0] = 32'hA5A5_0000;
        do_load(1'b0, 1'b0, 5);
        fetch_cyc(1'b1, 0);
        chk("word0_intact", 64'(bus.o_instr), 64'(32'hA5A5_0000));
        fetch_cyc(1'b1, DEPTH-1);

        // Random programs and fetch streams.
        for (int r = 0; r < 12; r++) begin
            int n;
            bit ul;
            n  = $urandom_range(1, DEPTH);
            ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            queue_random(n, 1'b1);
            do_load(ul, 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : -1);
            for (int k = 0; k < 20; k++)
                fetch_cyc(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, DEPTH-1)));
        end

        // Load start colliding with a fetch in RUN.
        fetch_cyc(1'b1, 7);
        queue_random(8, 1'b0);
        do_load(1'b1, 1'b1, -1);
        fetch_cyc(1'b1, 3);

        // Reset while word 2 of a load is presented.
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = $urandom;
            step();
            mdl[i] = bus.i_load_data;
        end
        bus.i_load_data = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        bus.i_load_valid = 1'b0;
        exp_instr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_fetch_en   = 1'b1;
            bus.i_fetch_addr = AW'(k);
            step();
            bus.i_fetch_en = 1'b0;
            chk("postrst_vld",   64'(bus.o_instr_valid), 64'(0));
            chk("postrst_busy",  64'(bus.o_busy),        64'(1));
            chk("postrst_instr", 64'(bus.o_instr),       64'(0));
        end
        queue_random(DEPTH, 1'b1);
        do_load(1'b0, 1'b0, -1);
        for (int k = 0; k < 16; k++)
            fetch_cyc(1'b1, int'($urandom_range(0, DEPTH-1)));

`ifdef INSTR_MEM_PARITY_EN
        // Inverted parity on word 1 only.
        wq = '{32'h1234_5678, 32'hDEAD_BEEF};
        iq = '{1'b0, 1'b1};
        do_load(1'b1, 1'b0, -1);
        fetch_cyc(1'b1, 1);
        chk("par_inj", 64'(par_err), 64'(1));
        fetch_cyc(1'b1, 0);
        chk("par_clean", 64'(par_err), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
